fifo_share_ctrl: RTL and testbench

FIFO_SHARE_CTRL -- requirements
Module: fifo_share_ctrl

---
 rtl/fifo_share_ctrl.sv | 122 ++++++++++++
 tb/tb_fifo_share_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_share_ctrl.sv
// Two-producer, one-consumer FIFO controller in front of an external RAM with a combinational read.
// Producers are arbitrated round-robin, and the popped word is registered on rd_data.
module fifo_share_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic [DATA_WIDTH-1:0] data0,
    output logic                  gnt0,
    input  logic                  req1,
    input  logic [DATA_WIDTH-1:0] data1,
    output logic                  gnt1,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  ovf,
    output logic                  udf
);

    localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    // last_grant_q = 1 means producer 1 won most recently.
    logic                  last_grant_q, last_grant_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  grant0, grant1, wr_fire, rd_fire;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                   (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst && !full) begin
            if (req0 && req1) begin
                grant0 = last_grant_q;
                grant1 = ~last_grant_q;
            end else begin
                grant0 = req0;
                grant1 = req1;
            end
        end
    end

    assign wr_fire = grant0 | grant1;
    assign rd_fire = rd_en & ~empty & ~rst;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        last_grant_d = last_grant_q;
        rd_data_d    = rd_data_q;
        rd_valid_d   = rd_fire;
        ovf_d        = ovf_q | ((req0 | req1) & full);
        udf_d        = udf_q | (rd_en & empty);
        if (wr_fire) begin
            wr_ptr_d     = wr_ptr_q + PTR_ONE;
            last_grant_d = grant1;
        end
        if (rd_fire) begin
            rd_ptr_d  = rd_ptr_q + PTR_ONE;
            rd_data_d = mem_rd_data;
        end
        if (wr_fire && !rd_fire) begin
            count_d = count_q + PTR_ONE;
        end else if (rd_fire && !wr_fire) begin
            count_d = count_q - PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            last_grant_q <= 1'b1;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            ovf_q        <= 1'b0;
            udf_q        <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            last_grant_q <= last_grant_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            ovf_q        <= ovf_d;
            udf_q        <= udf_d;
        end
    end

    assign gnt0        = grant0;
    assign gnt1        = grant1;
    assign mem_wr_en   = wr_fire;
    assign mem_wr_addr = wr_ptr_q[ADDR_WIDTH-1:0];
    assign mem_wr_data = grant0 ? data0 : (grant1 ? data1 : '0);
    assign mem_rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign count       = count_q;
    assign ovf         = ovf_q;
    assign udf         = udf_q;

endmodule

// File: tb/tb_fifo_share_ctrl.sv
// Self-checking bench for fifo_share_ctrl: a vector table, hand-written corner sequences, and a randomized run.
// The randomized run is compared against a queue-based reference model.
module tb_fifo_share_ctrl;

    logic       clk = 1'b0;
    logic       rst, req0, req1, rd_en;
    logic [7:0] data0, data1;
    logic       gnt0, gnt1, rd_valid, mem_wr_en, full, empty, ovf, udf;
    logic [7:0] rd_data, mem_wr_data, mem_rd_data;
    logic [2:0] mem_wr_addr, mem_rd_addr;
    logic [3:0] count;

    logic [7:0] ram [8];

    int checks = 0;
    int passes = 0;

    // Reference model: an ordered queue of accepted words plus a few scalars.
    logic [7:0] mq[$];
    int         m_last;
    int         m_writes;
    bit         m_ovf, m_udf, m_rvld;
    logic [7:0] m_rdata;
    bit         e_g0, e_g1;

    fifo_share_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .data0(data0), .gnt0(gnt0),
        .req1(req1), .data1(data1), .gnt1(gnt1),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .full(full), .empty(empty), .count(count), .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    // External RAM: synchronous write, combinational read.
    always @(posedge clk) begin
        if (mem_wr_en) ram[mem_wr_addr] <= mem_wr_data;
    end
    assign mem_rd_data = ram[mem_rd_addr];

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Predict this cycle's grants from the queue occupancy and the last winner.
    task automatic modelPredict();
        e_g0 = 1'b0;
        e_g1 = 1'b0;
        if (!rst && mq.size() < 8) begin
            if (req0 && req1) begin
                e_g0 = (m_last == 1);
                e_g1 = !e_g0;
            end else begin
                e_g0 = req0;
                e_g1 = req1;
            end
        end
    endtask

    task automatic modelCommit();
        bit pop;
        if (rst) begin
            mq.delete();
            m_last = 1; m_writes = 0;
            m_ovf = 0; m_udf = 0; m_rvld = 0; m_rdata = 8'h00;
        end else begin
            pop = rd_en && (mq.size() > 0);
            if ((req0 || req1) && mq.size() == 8) m_ovf = 1;
            if (rd_en && mq.size() == 0) m_udf = 1;
            m_rvld = pop;
            if (pop) m_rdata = mq.pop_front();
            if (e_g0) begin mq.push_back(data0); m_last = 0; m_writes++; end
            if (e_g1) begin mq.push_back(data1); m_last = 1; m_writes++; end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic q0, input logic [7:0] d0,
                                 input logic q1, input logic [7:0] d1, input logic rd);
        rst = r; req0 = q0; data0 = d0; req1 = q1; data1 = d1; rd_en = rd;
        #1;
        modelPredict();
    endtask

    task automatic tick();
        modelCommit();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic doReset();
        applyStimulus(1, 0, 8'h00, 0, 8'h00, 0);
        tick();
        tick();
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 0);
    endtask

    task automatic checkAgainstModel();
        logic [7:0] wd;
        wd = e_g0 ? data0 : (e_g1 ? data1 : 8'h00);
        checkOutput("rnd_gnt0", gnt0, e_g0);
        checkOutput("rnd_gnt1", gnt1, e_g1);
        checkOutput("rnd_wr_en", mem_wr_en, e_g0 | e_g1);
        checkOutput("rnd_wr_addr", mem_wr_addr, m_writes % 8);
        checkOutput("rnd_wr_data", mem_wr_data, wd);
        checkOutput("rnd_count", count, mq.size());
        checkOutput("rnd_empty", empty, mq.size() == 0);
        checkOutput("rnd_full", full, mq.size() == 8);
        checkOutput("rnd_rd_valid", rd_valid, m_rvld);
        checkOutput("rnd_rd_data", rd_data, m_rdata);
        checkOutput("rnd_ovf", ovf, m_ovf);
        checkOutput("rnd_udf", udf, m_udf);
    endtask

    typedef struct {
        logic       req0;  logic [7:0] d0;
        logic       req1;  logic [7:0] d1;
        logic       rd_en;
        logic       gnt0;  logic       gnt1;
        logic [2:0] waddr; logic [7:0] wdata;
        logic [3:0] count;
        logic       empty; logic       full;
        logic       rvld;  logic [7:0] rdata;
    } vec_t;

    vec_t vecs[12];

    initial begin
        bit hold0, hold1;

        vecs[0]  = '{0, 8'h00, 0, 8'h00, 0,  0, 0, 3'd0, 8'h00, 4'd0, 1, 0, 0, 8'h00};
        vecs[1]  = '{1, 8'hA1, 1, 8'hB1, 0,  1, 0, 3'd0, 8'hA1, 4'd0, 1, 0, 0, 8'h00};
        vecs[2]  = '{1, 8'hA2, 1, 8'hB2, 0,  0, 1, 3'd1, 8'hB2, 4'd1, 0, 0, 0, 8'h00};
        vecs[3]  = '{1, 8'hA3, 1, 8'hB3, 0,  1, 0, 3'd2, 8'hA3, 4'd2, 0, 0, 0, 8'h00};
        vecs[4]  = '{1, 8'hA4, 1, 8'hB4, 0,  0, 1, 3'd3, 8'hB4, 4'd3, 0, 0, 0, 8'h00};
        vecs[5]  = '{0, 8'h00, 0, 8'h00, 0,  0, 0, 3'd4, 8'h00, 4'd4, 0, 0, 0, 8'h00};
        vecs[6]  = '{0, 8'h00, 0, 8'h00, 1,  0, 0, 3'd4, 8'h00, 4'd4, 0, 0, 0, 8'h00};
        vecs[7]  = '{0, 8'h00, 0, 8'h00, 1,  0, 0, 3'd4, 8'h00, 4'd3, 0, 0, 1, 8'hA1};
        vecs[8]  = '{0, 8'h00, 1, 8'hC1, 1,  0, 1, 3'd4, 8'hC1, 4'd2, 0, 0, 1, 8'hB2};
        vecs[9]  = '{0, 8'h00, 0, 8'h00, 0,  0, 0, 3'd5, 8'h00, 4'd2, 0, 0, 1, 8'hA3};
        vecs[10] = '{0, 8'h00, 0, 8'h00, 0,  0, 0, 3'd5, 8'h00, 4'd2, 0, 0, 0, 8'hA3};
        vecs[11] = '{1, 8'hD0, 1, 8'hD1, 0,  1, 0, 3'd5, 8'hD0, 4'd2, 0, 0, 0, 8'hA3};

        @(negedge clk);
        doReset();

        // Vector table: contention order, RAM write path, pops, and simultaneous write+pop.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(0, vecs[i].req0, vecs[i].d0, vecs[i].req1, vecs[i].d1, vecs[i].rd_en);
            checkOutput($sformatf("vec%0d_gnt0", i), gnt0, vecs[i].gnt0);
            checkOutput($sformatf("vec%0d_gnt1", i), gnt1, vecs[i].gnt1);
            checkOutput($sformatf("vec%0d_wr_addr", i), mem_wr_addr, vecs[i].waddr);
            checkOutput($sformatf("vec%0d_wr_data", i), mem_wr_data, vecs[i].wdata);
            checkOutput($sformatf("vec%0d_count", i), count, vecs[i].count);
            checkOutput($sformatf("vec%0d_empty", i), empty, vecs[i].empty);
            checkOutput($sformatf("vec%0d_full", i), full, vecs[i].full);
            checkOutput($sformatf("vec%0d_rd_valid", i), rd_valid, vecs[i].rvld);
            checkOutput($sformatf("vec%0d_rd_data", i), rd_data, vecs[i].rdata);
            checkOutput($sformatf("vec%0d_ovf", i), ovf, 0);
            tick();
        end

        // Fill to full from producer 0, then overflow on a 9th request.
        doReset();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 1, 8'h11 + 8'(i), 0, 8'h00, 0);
            checkOutput($sformatf("fill%0d_gnt0", i), gnt0, 1);
            tick();
        end
        applyStimulus(0, 1, 8'h19, 0, 8'h00, 0);
        checkOutput("fill_full", full, 1);
        checkOutput("fill_count", count, 8);
        checkOutput("fill_ovf_gnt0", gnt0, 0);
        checkOutput("fill_ovf_wr_en", mem_wr_en, 0);
        tick();
        // Full with a write request and a pop: pop wins, write is retried next cycle.
        applyStimulus(0, 0, 8'h00, 1, 8'h77, 1);
        checkOutput("ovf_set", ovf, 1);
        checkOutput("fullpop_gnt1", gnt1, 0);
        tick();
        applyStimulus(0, 0, 8'h00, 1, 8'h77, 0);
        checkOutput("fullpop_count", count, 7);
        checkOutput("fullpop_rd_valid", rd_valid, 1);
        checkOutput("fullpop_rd_data", rd_data, 8'h11);
        checkOutput("retry_gnt1", gnt1, 1);
        tick();
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 0);
        checkOutput("retry_count", count, 8);

        // Single word pop, then underflow with rd_data held.
        doReset();
        applyStimulus(0, 1, 8'hA5, 0, 8'h00, 0);
        tick();
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 1);
        tick();
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 0);
        checkOutput("pop_rd_valid", rd_valid, 1);
        checkOutput("pop_rd_data", rd_data, 8'hA5);
        checkOutput("pop_empty", empty, 1);
        checkOutput("pop_count", count, 0);
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 1);
        tick();
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 0);
        checkOutput("udf_rd_valid", rd_valid, 0);
        checkOutput("udf_set", udf, 1);
        checkOutput("udf_rd_data", rd_data, 8'hA5);

        // Reset mid-operation with count 5 and ovf set.
        doReset();
        for (int i = 0; i < 9; i++) begin
            applyStimulus(0, 1, 8'h30 + 8'(i), 0, 8'h00, 0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 8'h00, 0, 8'h00, 1);
            tick();
        end
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 0);
        checkOutput("mid_count", count, 5);
        checkOutput("mid_ovf", ovf, 1);
        applyStimulus(1, 1, 8'h55, 1, 8'h66, 0);
        checkOutput("rst_gnt0", gnt0, 0);
        checkOutput("rst_gnt1", gnt1, 0);
        checkOutput("rst_wr_en", mem_wr_en, 0);
        tick();
        applyStimulus(0, 1, 8'h55, 1, 8'h66, 0);
        checkOutput("post_rst_count", count, 0);
        checkOutput("post_rst_empty", empty, 1);
        checkOutput("post_rst_ovf", ovf, 0);
        checkOutput("post_rst_gnt0", gnt0, 1);
        checkOutput("post_rst_gnt1", gnt1, 0);
        tick();

        // Randomized traffic against the reference model; producers hold req until granted.
        doReset();
        hold0 = 0;
        hold1 = 0;
        for (int c = 0; c < 600; c++) begin
            logic r, q0, q1, rd;
            logic [7:0] d0, d1;
            r  = ($urandom_range(0, 149) == 0);
            q0 = hold0 ? req0 : ($urandom_range(0, 1) == 1);
            d0 = hold0 ? data0 : 8'($urandom);
            q1 = hold1 ? req1 : ($urandom_range(0, 1) == 1);
            d1 = hold1 ? data1 : 8'($urandom);
            rd = ($urandom_range(0, 99) < 48);
            applyStimulus(r, q0, d0, q1, d1, rd);
            checkAgainstModel();
            hold0 = q0 && !e_g0 && !r;
            hold1 = q1 && !e_g1 && !r;
            tick();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
